// File: rtl/grant_pkg.sv
// Shared types and constants for the grant sequencer and its helpers.
`timescale 1ns / 1ps

package grant_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

endpackage

// File: rtl/grant_sequencer_if.sv
// Request/grant bundle between the sequencer, its requesters and the resolver.
`timescale 1ns / 1ps

interface grant_sequencer_if #(
  parameter int unsigned N = 16
) ();

  logic [N-1:0] request_in;
  logic         grant_done;
  logic [N-1:0] resolver_req;
  logic [N-1:0] resolver_grant;
  logic [N-1:0] grant_out;
  logic [3:0]   grant_index;
  logic         grant_valid;
  logic         timeout_pulse;
  logic [15:0]  served_count;
  logic         protocol_error;

  // Sequencer side.
  modport master (
    input  request_in,
    input  grant_done,
    input  resolver_grant,
    output resolver_req,
    output grant_out,
    output grant_index,
    output grant_valid,
    output timeout_pulse,
    output served_count,
    output protocol_error
  );

  // Requesters, resolver and downstream logic.
  modport slave (
    output request_in,
    output grant_done,
    output resolver_grant,
    input  resolver_req,
    input  grant_out,
    input  grant_index,
    input  grant_valid,
    input  timeout_pulse,
    input  served_count,
    input  protocol_error
  );

endinterface

// File: rtl/onehot_encoder.sv
// Converts an N-bit vector to a binary index and flags whether it is nonzero / one-hot.
// The index is only meaningful when the vector is one-hot.
`timescale 1ns / 1ps

module onehot_encoder #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] index,
  output logic          nonzero,
  output logic          onehot
);

  // OR together the indices of all set bits; exact for one-hot input.
  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        index = index | IW'(i);
      end
    end
  end

  assign nonzero = |vec;
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign onehot  = nonzero && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/grant_sequencer.sv
// Sequential stage around a combinational priority resolver: collects sticky requests,
// registers the resolver's one-hot answer and holds it until done or hold timeout.
`timescale 1ns / 1ps

module grant_sequencer
  import grant_pkg::*;
#(
  parameter int unsigned N        = N_REQ,
  parameter int unsigned HOLD_MAX = 255,
  parameter int unsigned HW       = 8
) (
  input logic              clk,
  input logic              rst_n,
  grant_sequencer_if.master bus
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] grant_q, grant_d;
  logic [3:0]   index_q, index_d;
  logic         valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;
  logic         timeout_q, timeout_d;
  logic [15:0]  served_q, served_d;
  logic         perr_q, perr_d;
  logic [N-1:0] clr_mask;

  logic [IDX_W-1:0] enc_index;
  logic             enc_nonzero;
  logic             enc_onehot;
  logic             legal;

  onehot_encoder #(
    .N  (N),
    .IW (IDX_W)
  ) u_encoder (
    .vec     (bus.resolver_grant),
    .index   (enc_index),
    .nonzero (enc_nonzero),
    .onehot  (enc_onehot)
  );

  // A grant is acceptable only if it picks exactly one unit that is actually pending.
  assign legal = enc_onehot && ((bus.resolver_grant & ~pending_q) == '0);

  // Next-state and next-output decode for the IDLE -> GRANT -> RELEASE cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    served_d  = served_q;
    perr_d    = perr_q;
    clr_mask  = '0;

    unique case (state_q)
      StIdle: begin
        if (enc_nonzero) begin
          if (legal) begin
            state_d = StGrant;
            grant_d = bus.resolver_grant;
            index_d = enc_index;
            valid_d = 1'b1;
            hold_d  = '0;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      StGrant: begin
        hold_d = hold_q + 1'b1;
        // Done takes priority over a coincident timeout, suppressing the pulse.
        if (bus.grant_done) begin
          state_d = StRelease;
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          state_d   = StRelease;
          timeout_d = 1'b1;
        end
      end
      StRelease: begin
        clr_mask = grant_q;
        served_d = served_q + 16'd1;
        state_d  = StIdle;
        grant_d  = '0;
        index_d  = '0;
        valid_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        index_d = '0;
        valid_d = 1'b0;
      end
    endcase

    // A new request on the bit being cleared wins, re-queueing that unit.
    pending_d = (pending_q & ~clr_mask) | bus.request_in;
  end

  // State and output registers; reset clears everything including pending requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      served_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      served_q  <= served_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.resolver_req   = pending_q;
  assign bus.grant_out      = grant_q;
  assign bus.grant_index    = index_q;
  assign bus.grant_valid    = valid_q;
  assign bus.timeout_pulse  = timeout_q;
  assign bus.served_count   = served_q;
  assign bus.protocol_error = perr_q;

endmodule
